// File: rtl/fpu_result_reader_if.sv
// Valid/ready stream carrying one FPU result (value plus IEEE exception flags).
// The master drives valid/data/flags and the slave drives ready.
interface fpu_result_reader_if #(
   parameter int unsigned SIZE  = 32,
   parameter int unsigned FLAGS = 5
);
   logic             valid;
   logic             ready;
   logic [SIZE-1:0]  data;
   logic [FLAGS-1:0] flags;

   modport master (
      output valid,
      output data,
      output flags,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  flags,
      output ready
   );
endinterface

// File: rtl/fpu_result_reader.sv
// FPU result drain: a 2-entry skid buffer between the FPU core and its consumer,
// plus a sticky exception-flag register fed by every result the consumer takes.
module fpu_result_reader #(
   parameter int unsigned SIZE  = 32,
   parameter int unsigned FLAGS = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   fpu_result_reader_if.slave  in_if,
   fpu_result_reader_if.master out_if,
   input  logic                flags_clr,
   output logic [FLAGS-1:0]    sticky_flags
);

   localparam int unsigned ENTRY_W = SIZE + FLAGS;

   logic [ENTRY_W-1:0] r_mem [2];
   logic               r_wr_ptr;
   logic               r_rd_ptr;
   logic [1:0]         r_count;
   logic [1:0]         w_count_nxt;
   logic [FLAGS-1:0]   r_sticky;
   logic [FLAGS-1:0]   w_sticky_nxt;
   logic [ENTRY_W-1:0] w_head;
   logic               w_in_ready;
   logic               w_out_valid;
   logic               w_push;
   logic               w_pop;

   // Status decodes come from the registered count only, so ready never sees out_ready.
   assign w_in_ready  = (r_count != 2'd2);
   assign w_out_valid = (r_count != 2'd0);
   assign w_push      = in_if.valid & w_in_ready;
   assign w_pop       = w_out_valid & out_if.ready;

   assign w_head       = r_mem[r_rd_ptr];
   assign in_if.ready  = w_in_ready;
   assign out_if.valid = w_out_valid;
   assign out_if.data  = w_head[ENTRY_W-1:FLAGS];
   assign out_if.flags = w_head[FLAGS-1:0];
   assign sticky_flags = r_sticky;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 2'd1;
         2'b01:   w_count_nxt = r_count - 2'd1;
         default: w_count_nxt = r_count;
      endcase
   end

   // A clear and a pop in the same cycle keep the popped flags.
   always_comb begin
      w_sticky_nxt = flags_clr ? FLAGS'(0) : r_sticky;
      if (w_pop) begin
         w_sticky_nxt = w_sticky_nxt | w_head[FLAGS-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         r_sticky <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         r_count  <= w_count_nxt;
         r_sticky <= w_sticky_nxt;
      end
   end

   // Storage resets too so the head mux reads zero while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= {in_if.data, in_if.flags};
      end
   end

endmodule

// File: tb/tb_fpu_result_reader.sv
// Directed bench for fpu_result_reader: a queue-based model checked every cycle
// plus literal expectations for reset, streaming, backpressure and sticky flags.
module tb_fpu_result_reader;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  f;
   } ent_t;

   logic        clk;
   logic        rst_n;
   logic        flags_clr;
   logic [4:0]  sticky_flags;

   fpu_result_reader_if #(.SIZE(32), .FLAGS(5)) in_if ();
   fpu_result_reader_if #(.SIZE(32), .FLAGS(5)) out_if ();

   fpu_result_reader #(.SIZE(32), .FLAGS(5)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_if        (in_if.slave),
      .out_if       (out_if.master),
      .flags_clr    (flags_clr),
      .sticky_flags (sticky_flags)
   );

   int n_checks = 0;
   int n_pass   = 0;

   ent_t        m_q[$];
   logic [4:0]  m_sticky = 5'd0;
   logic [31:0] popped[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a FIFO of at most two results and an OR-accumulator.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_sticky = 5'd0;
      end else begin
         bit   do_push;
         bit   do_pop;
         ent_t e;
         logic [4:0] pf;
         do_push = in_if.valid && (m_q.size() < 2);
         do_pop  = (m_q.size() > 0) && out_if.ready;
         pf = 5'd0;
         if (do_pop) begin
            pf = m_q[0].f;
            popped.push_back(m_q[0].d);
            m_q.pop_front();
         end
         m_sticky = (flags_clr ? 5'd0 : m_sticky) | pf;
         if (do_push) begin
            e.d = in_if.data;
            e.f = in_if.flags;
            m_q.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      chk("model_out_valid", 64'(out_if.valid), 64'(m_q.size() != 0));
      chk("model_in_ready", 64'(in_if.ready), 64'(m_q.size() != 2));
      chk("model_sticky", 64'(sticky_flags), 64'(m_sticky));
      if (m_q.size() != 0) begin
         chk("model_out_data", 64'(out_if.data), 64'(m_q[0].d));
         chk("model_out_flags", 64'(out_if.flags), 64'(m_q[0].f));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] f);
      in_if.valid = v;
      in_if.data  = d;
      in_if.flags = f;
   endtask

   // Drain the buffer with out_ready=1, bounded.
   task automatic drain();
      int n;
      out_if.ready = 1'b1;
      n = 0;
      while (out_if.valid && n < 10) begin
         step();
         n++;
      end
      chk("drain_empty", 64'(out_if.valid), 64'd0);
   endtask

   initial begin
      int   base;
      bit   acc;
      logic [31:0] exp_d[$];
      logic [31:0] v;

      rst_n = 1'b0;
      flags_clr = 1'b0;
      out_if.ready = 1'b0;
      drive(1'b0, 32'd0, 5'd0);
      step(); step();
      @(negedge clk) rst_n = 1'b1;
      step();
      chk("reset_out_valid", 64'(out_if.valid), 64'd0);
      chk("reset_in_ready", 64'(in_if.ready), 64'd1);
      chk("reset_sticky", 64'(sticky_flags), 64'd0);
      chk("reset_out_data", 64'(out_if.data), 64'd0);
      chk("reset_out_flags", 64'(out_if.flags), 64'd0);

      // Reset mid-stream with two results buffered.
      drive(1'b1, 32'h11111111, 5'b00001); step();
      drive(1'b1, 32'h22222222, 5'b00010); step();
      drive(1'b0, 32'd0, 5'd0);
      chk("midrst_full", 64'(in_if.ready), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_if.valid), 64'd0);
      chk("midrst_in_ready", 64'(in_if.ready), 64'd1);
      chk("midrst_sticky", 64'(sticky_flags), 64'd0);
      chk("midrst_out_data", 64'(out_if.data), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      step();
      drive(1'b1, 32'h3F800000, 5'd0); step();
      drive(1'b0, 32'd0, 5'd0);
      chk("postrst_valid", 64'(out_if.valid), 64'd1);
      chk("postrst_data", 64'(out_if.data), 64'h3F800000);
      drain();

      // Streaming 1..8 with out_ready held high.
      base = popped.size();
      out_if.ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 32'(i), 5'd0);
         step();
         chk("stream_in_ready", 64'(in_if.ready), 64'd1);
         chk("stream_out_data", 64'(out_if.data), 64'(i));
      end
      drive(1'b0, 32'd0, 5'd0);
      drain();
      chk("stream_count", 64'(popped.size() - base), 64'd8);
      for (int i = 0; i < 8 && base + i < popped.size(); i++) begin
         chk("stream_order", 64'(popped[base + i]), 64'(i + 1));
      end

      // Backpressure: A, B fill the buffer, C is held until room appears.
      base = popped.size();
      out_if.ready = 1'b0;
      drive(1'b1, 32'h40000000, 5'd0); step();
      drive(1'b1, 32'h40400000, 5'd0); step();
      chk("bp_full_ready", 64'(in_if.ready), 64'd0);
      drive(1'b1, 32'h40800000, 5'd0);
      step(); step();
      chk("bp_hold_ready", 64'(in_if.ready), 64'd0);
      chk("bp_hold_data", 64'(out_if.data), 64'h40000000);
      out_if.ready = 1'b1;
      acc = 1'b0;
      for (int n = 0; n < 10 && !acc; n++) begin
         acc = in_if.ready;
         step();
      end
      chk("bp_c_accepted", 64'(acc), 64'd1);
      drive(1'b0, 32'd0, 5'd0);
      drain();
      exp_d = '{32'h40000000, 32'h40400000, 32'h40800000};
      chk("bp_count", 64'(popped.size() - base), 64'd3);
      for (int i = 0; i < 3 && base + i < popped.size(); i++) begin
         chk("bp_order", 64'(popped[base + i]), 64'(exp_d[i]));
      end

      // Simultaneous push/pop at count=1 across pointer wraps.
      base = popped.size();
      out_if.ready = 1'b0;
      drive(1'b1, 32'hD0D0D000, 5'd0); step();
      out_if.ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         v = 32'hD0D0D000 + 32'(k);
         drive(1'b1, v, 5'd0);
         step();
         chk("pp_valid", 64'(out_if.valid), 64'd1);
         chk("pp_ready", 64'(in_if.ready), 64'd1);
         chk("pp_data", 64'(out_if.data), 64'(v));
      end
      drive(1'b0, 32'd0, 5'd0);
      drain();
      chk("pp_count", 64'(popped.size() - base), 64'd5);
      for (int i = 0; i < 5 && base + i < popped.size(); i++) begin
         chk("pp_order", 64'(popped[base + i]), 64'(32'hD0D0D000 + 32'(i)));
      end

      // Sticky accumulation, then clear coincident with a pop.
      out_if.ready = 1'b0;
      flags_clr = 1'b1; step(); flags_clr = 1'b0;
      chk("sticky_cleared", 64'(sticky_flags), 64'd0);
      drive(1'b1, 32'hAAAA0001, 5'b00001); step();
      drive(1'b1, 32'hAAAA0002, 5'b10000); step();
      drive(1'b0, 32'd0, 5'd0);
      chk("sticky_unpopped", 64'(sticky_flags), 64'd0);
      out_if.ready = 1'b1;
      step();
      chk("sticky_first", 64'(sticky_flags), 64'b00001);
      step();
      chk("sticky_or", 64'(sticky_flags), 64'b10001);
      out_if.ready = 1'b0;
      drive(1'b1, 32'hAAAA0003, 5'b00100); step();
      drive(1'b0, 32'd0, 5'd0);
      chk("sticky_hold", 64'(sticky_flags), 64'b10001);
      out_if.ready = 1'b1;
      flags_clr = 1'b1;
      step();
      flags_clr = 1'b0;
      out_if.ready = 1'b0;
      chk("sticky_clr_pop", 64'(sticky_flags), 64'b00100);

      // A buffered result contributes nothing until it is popped.
      flags_clr = 1'b1; step(); flags_clr = 1'b0;
      drive(1'b1, 32'hBBBB0000, 5'b01000); step();
      drive(1'b0, 32'd0, 5'd0);
      step(); step();
      chk("unpop_sticky", 64'(sticky_flags), 64'd0);
      chk("unpop_flags", 64'(out_if.flags), 64'b01000);
      out_if.ready = 1'b1;
      step();
      out_if.ready = 1'b0;
      chk("unpop_after_pop", 64'(sticky_flags), 64'b01000);
      step(); step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
